// File: rtl/logic_pipe_checker.sv
// logic_pipe_checker: online checker for an upstream registered f1/f2 block
// (f1 = previous a|b, f2 = previous f1&c). Keeps one cycle of operand history,
// compares each CHECK cycle and records counts plus first-error information.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   en              checking enable (sampled on posedge clk)
//   clr             synchronous clear of counters, flags and FSM (beats en)
//   a, b, c         upstream operand lines
//   f1, f2          upstream registered results under test
//   busy            high while the FSM is in CHECK (registered)
//   chk_cnt         number of cycles checked (wraps)
//   err_cnt         number of cycles with any mismatch (saturates)
//   err_sticky      set on first mismatch, held until clr/reset
//   first_err       mismatch type at first error {f2 wrong, f1 wrong}
//   first_idx       chk_cnt value at the first error
module logic_pipe_checker #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ERR_W       = 8,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             f1,
  input  logic             f2,
  output logic             busy,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic [1:0]       first_err,
  output logic [CNT_W-1:0] first_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WARM  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_a_q;
  logic             r_b_q;
  logic             r_c_q;
  logic             r_f1_q;

  logic             r_busy;
  logic [CNT_W-1:0] r_chk_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_err_sticky;
  logic [1:0]       r_first_err;
  logic [CNT_W-1:0] r_first_idx;

  logic [CNT_W-1:0] w_chk_nxt;
  logic [ERR_W-1:0] w_err_nxt;
  logic             w_sticky_nxt;
  logic [1:0]       w_ferr_nxt;
  logic [CNT_W-1:0] w_fidx_nxt;

  logic             w_exp_f1;
  logic             w_exp_f2;
  logic [1:0]       w_mism;

  // Expected results rebuilt from last cycle's operands.
  assign w_exp_f1 = r_a_q | r_b_q;
  assign w_exp_f2 = r_f1_q & r_c_q;
  assign w_mism   = {f2 != w_exp_f2, f1 != w_exp_f1};

  // History follows the upstream block every cycle; reset mirrors its reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q  <= 1'b1;
      r_b_q  <= 1'b0;
      r_c_q  <= 1'b1;
      r_f1_q <= 1'b1;
    end else begin
      r_a_q  <= a;
      r_b_q  <= b;
      r_c_q  <= c;
      r_f1_q <= f1;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_chk_cnt    <= '0;
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
      r_first_err  <= 2'b00;
      r_first_idx  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= (w_state_nxt == ST_CHECK);
      r_chk_cnt    <= w_chk_nxt;
      r_err_cnt    <= w_err_nxt;
      r_err_sticky <= w_sticky_nxt;
      r_first_err  <= w_ferr_nxt;
      r_first_idx  <= w_fidx_nxt;
    end
  end

  // Next-state and counter update; clr overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_chk_nxt    = r_chk_cnt;
    w_err_nxt    = r_err_cnt;
    w_sticky_nxt = r_err_sticky;
    w_ferr_nxt   = r_first_err;
    w_fidx_nxt   = r_first_idx;

    if (clr) begin
      w_state_nxt  = ST_IDLE;
      w_chk_nxt    = '0;
      w_err_nxt    = '0;
      w_sticky_nxt = 1'b0;
      w_ferr_nxt   = 2'b00;
      w_fidx_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) w_state_nxt = ST_WARM;
        end
        ST_WARM: begin
          w_state_nxt = en ? ST_CHECK : ST_IDLE;
        end
        ST_CHECK: begin
          if (!en) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_chk_nxt = r_chk_cnt + CNT_W'(1);
            if (w_mism != 2'b00) begin
              if (r_err_cnt != ERR_MAX) w_err_nxt = r_err_cnt + ERR_W'(1);
              if (!r_err_sticky) begin
                w_sticky_nxt = 1'b1;
                w_ferr_nxt   = w_mism;
                w_fidx_nxt   = r_chk_cnt;
              end
              if (STOP_ON_ERR) w_state_nxt = ST_FAIL;
            end
          end
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign chk_cnt    = r_chk_cnt;
  assign err_cnt    = r_err_cnt;
  assign err_sticky = r_err_sticky;
  assign first_err  = r_first_err;
  assign first_idx  = r_first_idx;

endmodule

// File: tb/tb_logic_pipe_checker.sv
// Bench for logic_pipe_checker: three instances (default, stop-on-error,
// narrow counters) share one stimulus stream built from an upstream model.
module tb_logic_pipe_checker;

  logic clk = 1'b0;
  logic rst_n, en, clr, a, b, c, f1, f2;

  logic        d0_busy, d0_st;
  logic [15:0] d0_chk, d0_fidx;
  logic [7:0]  d0_err;
  logic [1:0]  d0_ferr;

  logic        d1_busy, d1_st;
  logic [15:0] d1_chk, d1_fidx;
  logic [7:0]  d1_err;
  logic [1:0]  d1_ferr;

  logic        d2_busy, d2_st;
  logic [3:0]  d2_chk, d2_fidx;
  logic [1:0]  d2_err;
  logic [1:0]  d2_ferr;

  int checks = 0;
  int failures = 0;

  // Upstream model state: previous a, b, c and previous driven f1.
  logic p_a, p_b, p_c, p_f1;

  always #5 clk = ~clk;

  logic_pipe_checker #(.CNT_W(16), .ERR_W(8), .STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c), .f1(f1), .f2(f2),
    .busy(d0_busy), .chk_cnt(d0_chk), .err_cnt(d0_err), .err_sticky(d0_st),
    .first_err(d0_ferr), .first_idx(d0_fidx));

  logic_pipe_checker #(.CNT_W(16), .ERR_W(8), .STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c), .f1(f1), .f2(f2),
    .busy(d1_busy), .chk_cnt(d1_chk), .err_cnt(d1_err), .err_sticky(d1_st),
    .first_err(d1_ferr), .first_idx(d1_fidx));

  logic_pipe_checker #(.CNT_W(4), .ERR_W(2), .STOP_ON_ERR(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c), .f1(f1), .f2(f2),
    .busy(d2_busy), .chk_cnt(d2_chk), .err_cnt(d2_err), .err_sticky(d2_st),
    .first_err(d2_ferr), .first_idx(d2_fidx));

  typedef struct {
    logic en, clr, a, b, c, e1, e2;
    logic busy; int chk; int err; logic st; logic [1:0] ferr; int fidx;
    logic xbusy; int xchk; int xerr;
  } vec_t;

  localparam int NV = 20;
  vec_t v[NV];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs; e1/e2 corrupt the upstream results.
  task automatic drive(input logic en_i, input logic clr_i, input logic a_i,
                       input logic b_i, input logic c_i, input logic e1, input logic e2);
    en  = en_i;
    clr = clr_i;
    a   = a_i;
    b   = b_i;
    c   = c_i;
    f1  = (p_a | p_b) ^ e1;
    f2  = (p_f1 & p_c) ^ e2;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      p_a = 1'b1; p_b = 1'b0; p_c = 1'b1; p_f1 = 1'b1;
    end else begin
      p_a = a; p_b = b; p_c = c; p_f1 = f1;
    end
    #1;
  endtask

  task automatic rnd_cycle(input logic en_i, input logic clr_i, input logic e1);
    drive(en_i, clr_i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), e1, 1'b0);
    cycle();
  endtask

  initial begin
    //       en clr a  b  c  e1 e2  busy chk err st ferr fidx  xbusy xchk xerr
    v[0]  = '{1, 0, 1, 0, 1, 0, 0,  0,   0,  0,  0, 0,   0,    0,    0,   0};
    v[1]  = '{1, 0, 1, 0, 1, 0, 0,  1,   0,  0,  0, 0,   0,    1,    0,   0};
    v[2]  = '{1, 0, 0, 1, 1, 0, 0,  1,   1,  0,  0, 0,   0,    1,    1,   0};
    v[3]  = '{1, 0, 0, 0, 0, 0, 0,  1,   2,  0,  0, 0,   0,    1,    2,   0};
    v[4]  = '{1, 0, 1, 1, 0, 0, 0,  1,   3,  0,  0, 0,   0,    1,    3,   0};
    v[5]  = '{1, 0, 0, 1, 0, 0, 0,  1,   4,  0,  0, 0,   0,    1,    4,   0};
    v[6]  = '{1, 0, 1, 0, 1, 0, 0,  1,   5,  0,  0, 0,   0,    1,    5,   0};
    v[7]  = '{1, 0, 0, 0, 1, 0, 1,  1,   6,  1,  1, 2,   5,    0,    6,   1};
    v[8]  = '{1, 0, 1, 0, 0, 1, 0,  1,   7,  2,  1, 2,   5,    0,    6,   1};
    v[9]  = '{1, 0, 0, 1, 1, 0, 0,  1,   8,  2,  1, 2,   5,    0,    6,   1};
    v[10] = '{0, 0, 1, 1, 1, 0, 0,  0,   8,  2,  1, 2,   5,    0,    6,   1};
    v[11] = '{0, 0, 0, 0, 1, 0, 0,  0,   8,  2,  1, 2,   5,    0,    6,   1};
    v[12] = '{1, 0, 1, 0, 1, 0, 0,  0,   8,  2,  1, 2,   5,    0,    6,   1};
    v[13] = '{1, 0, 1, 1, 0, 0, 0,  1,   8,  2,  1, 2,   5,    0,    6,   1};
    v[14] = '{1, 0, 0, 1, 1, 1, 1,  1,   9,  3,  1, 2,   5,    0,    6,   1};
    v[15] = '{1, 1, 1, 0, 1, 0, 0,  0,   0,  0,  0, 0,   0,    0,    0,   0};
    v[16] = '{1, 0, 1, 0, 1, 0, 0,  0,   0,  0,  0, 0,   0,    0,    0,   0};
    v[17] = '{1, 0, 0, 1, 1, 0, 0,  1,   0,  0,  0, 0,   0,    1,    0,   0};
    v[18] = '{1, 0, 1, 0, 1, 1, 0,  1,   1,  1,  1, 1,   0,    0,    1,   1};
    v[19] = '{0, 0, 1, 0, 1, 0, 0,  0,   1,  1,  1, 1,   0,    0,    1,   1};

    // Reset state
    rst_n = 1'b0;
    p_a = 1'b1; p_b = 1'b0; p_c = 1'b1; p_f1 = 1'b1;
    drive(0, 0, 1, 0, 1, 0, 0);
    #3;
    chk("rst busy", int'(d0_busy), 0);
    chk("rst chk_cnt", int'(d0_chk), 0);
    chk("rst err_cnt", int'(d0_err), 0);
    chk("rst sticky", int'(d0_st), 0);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      drive(v[i].en, v[i].clr, v[i].a, v[i].b, v[i].c, v[i].e1, v[i].e2);
      cycle();
      chk($sformatf("v%0d d0 busy", i), int'(d0_busy), int'(v[i].busy));
      chk($sformatf("v%0d d0 chk_cnt", i), int'(d0_chk), v[i].chk);
      chk($sformatf("v%0d d0 err_cnt", i), int'(d0_err), v[i].err);
      chk($sformatf("v%0d d0 sticky", i), int'(d0_st), int'(v[i].st));
      chk($sformatf("v%0d d0 first_err", i), int'(d0_ferr), int'(v[i].ferr));
      chk($sformatf("v%0d d0 first_idx", i), int'(d0_fidx), v[i].fidx);
      chk($sformatf("v%0d d1 busy", i), int'(d1_busy), int'(v[i].xbusy));
      chk($sformatf("v%0d d1 chk_cnt", i), int'(d1_chk), v[i].xchk);
      chk($sformatf("v%0d d1 err_cnt", i), int'(d1_err), v[i].xerr);
      chk($sformatf("v%0d d1 sticky", i), int'(d1_st), int'(v[i].st));
      chk($sformatf("v%0d d1 first_err", i), int'(d1_ferr), int'(v[i].ferr));
      chk($sformatf("v%0d d2 chk_cnt", i), int'(d2_chk), v[i].chk % 16);
      chk($sformatf("v%0d d2 err_cnt", i), int'(d2_err), (v[i].err > 3) ? 3 : v[i].err);
    end

    // Long clean run: busy from second edge, 4-bit counter wrap, 99 checks
    rnd_cycle(0, 1, 0);
    chk("clr d1 chk_cnt", int'(d1_chk), 0);
    chk("clr d1 busy", int'(d1_busy), 0);
    rnd_cycle(1, 0, 0);
    chk("long busy edge1", int'(d0_busy), 0);
    rnd_cycle(1, 0, 0);
    chk("long busy edge2", int'(d0_busy), 1);
    for (int k = 3; k <= 101; k++) begin
      rnd_cycle(1, 0, 0);
      if (k == 19) begin
        chk("wrap d2 chk_cnt", int'(d2_chk), 1);
        chk("wrap d0 chk_cnt", int'(d0_chk), 17);
      end
    end
    chk("long d0 chk_cnt", int'(d0_chk), 99);
    chk("long d0 err_cnt", int'(d0_err), 0);
    chk("long d0 sticky", int'(d0_st), 0);
    chk("long d0 busy", int'(d0_busy), 1);
    chk("long d2 chk_cnt", int'(d2_chk), 3);

    // Stop-on-error freeze at chk_cnt=3, then clr
    rnd_cycle(1, 1, 0);
    rnd_cycle(1, 0, 0);
    rnd_cycle(1, 0, 0);
    for (int k = 0; k < 3; k++) rnd_cycle(1, 0, 0);
    chk("stop pre d1 chk_cnt", int'(d1_chk), 3);
    rnd_cycle(1, 0, 1);
    chk("stop d1 chk_cnt", int'(d1_chk), 4);
    chk("stop d1 busy", int'(d1_busy), 0);
    chk("stop d1 first_err", int'(d1_ferr), 1);
    chk("stop d1 first_idx", int'(d1_fidx), 3);
    chk("stop d1 err_cnt", int'(d1_err), 1);
    chk("stop d0 busy", int'(d0_busy), 1);
    for (int k = 0; k < 3; k++) rnd_cycle(1, 0, 0);
    chk("frozen d1 chk_cnt", int'(d1_chk), 4);
    chk("frozen d1 busy", int'(d1_busy), 0);
    chk("running d0 chk_cnt", int'(d0_chk), 7);
    rnd_cycle(1, 1, 0);
    chk("clr2 d1 chk_cnt", int'(d1_chk), 0);
    chk("clr2 d1 err_cnt", int'(d1_err), 0);
    chk("clr2 d1 sticky", int'(d1_st), 0);
    chk("clr2 d1 first_err", int'(d1_ferr), 0);
    chk("clr2 d1 first_idx", int'(d1_fidx), 0);
    rnd_cycle(1, 0, 0);
    chk("clr2 warm busy", int'(d1_busy), 0);
    rnd_cycle(1, 0, 0);
    chk("clr2 check busy", int'(d1_busy), 1);

    // Mismatch every cycle for 10 checks: saturation on the 2-bit counter
    rnd_cycle(1, 1, 0);
    rnd_cycle(1, 0, 0);
    rnd_cycle(1, 0, 0);
    for (int k = 0; k < 10; k++) rnd_cycle(1, 0, 1);
    chk("sat d2 err_cnt", int'(d2_err), 3);
    chk("sat d2 first_idx", int'(d2_fidx), 0);
    chk("sat d2 first_err", int'(d2_ferr), 1);
    chk("sat d2 chk_cnt", int'(d2_chk), 10);
    chk("sat d0 err_cnt", int'(d0_err), 10);
    chk("sat d1 chk_cnt", int'(d1_chk), 1);

    // Asynchronous reset mid-CHECK with err_cnt=2
    rnd_cycle(1, 1, 0);
    rnd_cycle(1, 0, 0);
    rnd_cycle(1, 0, 0);
    rnd_cycle(1, 0, 1);
    rnd_cycle(1, 0, 1);
    chk("pre-rst d0 err_cnt", int'(d0_err), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst d0 busy", int'(d0_busy), 0);
    chk("arst d0 chk_cnt", int'(d0_chk), 0);
    chk("arst d0 err_cnt", int'(d0_err), 0);
    chk("arst d0 sticky", int'(d0_st), 0);
    chk("arst d0 first_err", int'(d0_ferr), 0);
    chk("arst d2 err_cnt", int'(d2_err), 0);
    drive(0, 0, 1, 0, 1, 0, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 1, 0, 0);
    cycle();
    chk("post-rst idle busy a", int'(d0_busy), 0);
    drive(0, 0, 1, 0, 1, 0, 0);
    cycle();
    chk("post-rst idle busy b", int'(d0_busy), 0);
    drive(1, 0, 1, 0, 1, 0, 0);
    cycle();
    chk("post-rst warm busy", int'(d0_busy), 0);
    drive(1, 0, 1, 0, 1, 0, 0);
    cycle();
    chk("post-rst check busy", int'(d0_busy), 1);
    chk("post-rst chk_cnt", int'(d0_chk), 0);
    drive(1, 0, 1, 0, 1, 0, 0);
    cycle();
    chk("post-rst first check", int'(d0_chk), 1);
    chk("post-rst err_cnt", int'(d0_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
